// File: rtl/led_status_tx.sv
// ---------------------------------------------------------------------------
// led_status_tx
//
// Reports the red-LED vector back to the host over the board UART. A report
// is a fixed 17-byte ASCII line, "LEDR=" + ten '0'/'1' characters for
// ledr_state[9] down to [0] + CR LF, sent as back-to-back 8N1 frames.
//
// A report starts on report_req, or automatically (AUTO_REPORT=1) whenever
// ledr_state differs from its previous-cycle value. The LED vector is
// snapshotted in the cycle the message starts, so later changes never alter
// a message already in flight. Triggers that arrive while a message is in
// flight coalesce into a single follow-up message.
//
// Request contract: report_req is a single-cycle pulse that is never
// refused. If it lands while busy is high it is remembered and served by
// exactly one follow-up message that starts one cycle after done pulses.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous, active-high reset
//   ledr_state : 10-bit LED vector to report
//   report_req : single-cycle report request
//   uart_txd   : serial output, idles high
//   busy       : high while a message is in flight
//   done       : one-cycle pulse when the last stop bit completes
// ---------------------------------------------------------------------------
module led_status_tx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter bit AUTO_REPORT  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] ledr_state,
    input  logic       report_req,
    output logic       uart_txd,
    output logic       busy,
    output logic       done
);

    localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [4:0]    LAST_BYTE = 5'd16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [4:0]    byte_idx;
    logic [9:0]    snap;
    logic [9:0]    prev_ledr;
    logic          pending;

    logic [7:0]    cur_byte;
    logic          led_bit;
    logic          changed;
    logic          bit_end;
    logic          trigger;

    assign changed = AUTO_REPORT && (ledr_state != prev_ledr);
    assign bit_end = (baud_cnt == BAUD_LAST);
    assign trigger = report_req || pending;

    // Character for the current byte index. Indices 5..14 carry
    // snap[9] down to snap[0].
    always_comb begin
        led_bit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (byte_idx == 5'(14 - i)) led_bit = snap[i];
        end
        cur_byte = 8'h30;
        case (byte_idx)
            5'd0:    cur_byte = 8'h4C;  // 'L'
            5'd1:    cur_byte = 8'h45;  // 'E'
            5'd2:    cur_byte = 8'h44;  // 'D'
            5'd3:    cur_byte = 8'h52;  // 'R'
            5'd4:    cur_byte = 8'h3D;  // '='
            5'd15:   cur_byte = 8'h0D;  // CR
            5'd16:   cur_byte = 8'h0A;  // LF
            default: cur_byte = led_bit ? 8'h31 : 8'h30;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            byte_idx  <= '0;
            snap      <= '0;
            prev_ledr <= '0;
            pending   <= 1'b0;
            uart_txd  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            prev_ledr <= ledr_state;
            done      <= 1'b0;

            // Starting a message consumes every trigger present in that
            // cycle (the snapshot already reflects the current LEDs).
            // report_req outside IDLE and any LED change otherwise latch.
            if (state == IDLE && trigger) begin
                pending <= 1'b0;
            end else if (changed || report_req) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state    <= START;
                        busy     <= 1'b1;
                        uart_txd <= 1'b0;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        byte_idx <= '0;
                        snap     <= ledr_state;
                    end
                end

                START: begin
                    if (bit_end) begin
                        state    <= DATA;
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        uart_txd <= cur_byte[0];
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            state    <= STOP;
                            uart_txd <= 1'b1;
                        end else begin
                            bit_cnt  <= bit_cnt + 3'd1;
                            uart_txd <= cur_byte[bit_cnt + 3'd1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (byte_idx == LAST_BYTE) begin
                            state    <= IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            byte_idx <= '0;
                        end else begin
                            // Next frame's start bit follows with no gap.
                            state    <= START;
                            byte_idx <= byte_idx + 5'd1;
                            uart_txd <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_status_tx.sv
// ---------------------------------------------------------------------------
// tb_led_status_tx
//
// Two instances share clock and reset: instance 0 has AUTO_REPORT=1,
// instance 1 has AUTO_REPORT=0. Both run at CLKS_PER_BIT=10. A message-level
// reference model predicts txd/busy/done for every cycle from the message
// start time and snapshot; a UART decoder on instance 0 checks the received
// bytes against the expected byte queue.
// ---------------------------------------------------------------------------
module tb_led_status_tx;

    localparam int CPB     = 10;
    localparam int MSG_CYC = 170 * CPB;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [9:0] ledr [2];
    logic       req  [2];
    logic       txd  [2];
    logic       busy [2];
    logic       done [2];

    led_status_tx #(.CLK_FREQ(1000), .BAUD(100), .AUTO_REPORT(1'b1)) dut_auto (
        .clk        (clk),
        .rst        (rst),
        .ledr_state (ledr[0]),
        .report_req (req[0]),
        .uart_txd   (txd[0]),
        .busy       (busy[0]),
        .done       (done[0])
    );

    led_status_tx #(.CLK_FREQ(1000), .BAUD(100), .AUTO_REPORT(1'b0)) dut_man (
        .clk        (clk),
        .rst        (rst),
        .ledr_state (ledr[1]),
        .report_req (req[1]),
        .uart_txd   (txd[1]),
        .busy       (busy[1]),
        .done       (done[1])
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q [$];
    logic [7:0] rx_log [$];
    int         busy_cnt [2];
    int         done_cnt [2];
    int         lo_cnt   [2];

    // ---------------- reference model state ----------------
    logic       m_active [2];
    int         m_k      [2];
    logic       m_pend   [2];
    logic [9:0] m_prev   [2];
    logic       m_done   [2];
    string      m_msg    [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic next_s();
        @(posedge clk);
        #1;
    endtask

    // Expected serial level: frame = k / (10 bit times), bit within frame
    // 0 = start, 1..8 = data LSB first, 9 = stop.
    function automatic logic exp_txd(input int d);
        string      s;
        int         frame;
        int         b;
        logic [7:0] c;
        if (!m_active[d]) return 1'b1;
        frame = m_k[d] / (10 * CPB);
        b     = (m_k[d] % (10 * CPB)) / CPB;
        s     = m_msg[d];
        c     = 8'(s[frame]);
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return c[b-1];
    endfunction

    function automatic int msg_diff(input string s);
        int n;
        n = 0;
        if (rx_log.size() != s.len()) n++;
        for (int i = 0; i < s.len() && i < rx_log.size(); i++) begin
            if (rx_log[i] != 8'(s[i])) n++;
        end
        return n;
    endfunction

    // ---------------- reference model ----------------
    initial begin : model
        logic  chg;
        string s;
        for (int d = 0; d < 2; d++) begin
            m_active[d] = 1'b0; m_k[d] = 0; m_pend[d] = 1'b0;
            m_prev[d] = '0; m_done[d] = 1'b0; m_msg[d] = "";
        end
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int d = 0; d < 2; d++) begin
                    m_active[d] = 1'b0; m_k[d] = 0; m_pend[d] = 1'b0;
                    m_prev[d] = '0; m_done[d] = 1'b0;
                end
                exp_q.delete();
            end else begin
                for (int d = 0; d < 2; d++) begin
                    // only instance 0 reports on LED changes
                    chg       = (d == 0) && (ledr[d] != m_prev[d]);
                    m_prev[d] = ledr[d];
                    m_done[d] = 1'b0;
                    if (m_active[d]) begin
                        if (req[d] || chg) m_pend[d] = 1'b1;
                        m_k[d]++;
                        if (m_k[d] == MSG_CYC) begin
                            m_active[d] = 1'b0;
                            m_done[d]   = 1'b1;
                        end
                    end else if (req[d] || m_pend[d]) begin
                        m_active[d] = 1'b1;
                        m_k[d]      = 0;
                        m_pend[d]   = 1'b0;
                        s           = $sformatf("LEDR=%b\r\n", ledr[d]);
                        m_msg[d]    = s;
                        if (d == 0) begin
                            for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
                        end
                    end else if (chg) begin
                        m_pend[d] = 1'b1;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin : compare
        logic [2:0] act;
        logic [2:0] exp;
        for (int d = 0; d < 2; d++) begin
            busy_cnt[d] = 0; done_cnt[d] = 0; lo_cnt[d] = 0;
        end
        forever begin
            next_s();
            for (int d = 0; d < 2; d++) begin
                act = {txd[d], busy[d], done[d]};
                exp = {exp_txd(d), m_active[d], m_done[d]};
                check($sformatf("cycle_dut%0d{txd,busy,done}", d), 32'(act), 32'(exp));
                if (!rst) begin
                    busy_cnt[d] += int'(busy[d]);
                    done_cnt[d] += int'(done[d]);
                    lo_cnt[d]   += int'(!txd[d]);
                end
            end
        end
    end

    // ---------------- UART decoder on instance 0 ----------------
    initial begin : monitor
        logic [7:0] data;
        logic [7:0] e;
        logic       stop_b;
        data = '0;
        forever begin
            next_s();
            if (!rst && txd[0] == 1'b0) begin
                repeat (CPB / 2) next_s();
                if (txd[0] == 1'b0) begin
                    for (int j = 0; j < 8; j++) begin
                        repeat (CPB) next_s();
                        data[j] = txd[0];
                    end
                    repeat (CPB) next_s();
                    stop_b = txd[0];
                    rx_log.push_back(data);
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_errors++;
                        $display("FAIL rx_byte: got 'h%02h, expected no byte", data);
                    end else begin
                        e = exp_q.pop_front();
                        if (data !== e || stop_b !== 1'b1) begin
                            n_errors++;
                            $display("FAIL rx_byte: got 'h%02h stop=%0b, expected 'h%02h stop=1",
                                     data, stop_b, e);
                        end
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_req(input int d);
        @(negedge clk);
        req[d] = 1'b1;
        @(negedge clk);
        req[d] = 1'b0;
    endtask

    // what: 0 = busy high, 1 = busy low, 2 = done high
    task automatic wait_for(input int d, input int what, input int budget, input string name);
        int   n;
        logic hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            next_s();
            n++;
            case (what)
                0:       hit = busy[d];
                1:       hit = !busy[d];
                default: hit = done[d];
            endcase
        end
        check(name, 32'(hit), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        logic       wave [100];
        logic [9:0] pat;
        int         bad;
        int         gap;

        for (int d = 0; d < 2; d++) begin
            ledr[d] = '0;
            req[d]  = 1'b0;
        end
        rst = 1'b1;
        repeat (3) next_s();
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_txd%0d", d),  32'(txd[d]),  32'd1);
            check($sformatf("reset_busy%0d", d), 32'(busy[d]), 32'd0);
            check($sformatf("reset_done%0d", d), 32'(done[d]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) next_s();
        check("idle_after_reset", 32'(busy[0]), 32'd0);

        // Basic report: request together with an LED change -> one message.
        rx_log.delete();
        @(negedge clk);
        busy_cnt[0] = 0; done_cnt[0] = 0;
        ledr[0] = 10'b0000000001;
        req[0]  = 1'b1;
        @(negedge clk);
        req[0]  = 1'b0;
        wait_for(0, 1, 2000, "basic_finish");
        repeat (20) next_s();
        check("basic_msg_diff", 32'(msg_diff("LEDR=0000000001\r\n")), 32'd0);
        check("basic_busy_cycles", 32'(busy_cnt[0]), 32'd1700);
        check("basic_done_count", 32'(done_cnt[0]), 32'd1);

        // Bit timing of byte 0 with all LEDs on.
        rx_log.delete();
        pat = 10'b1010011000;
        @(negedge clk);
        ledr[0] = 10'h3FF;
        req[0]  = 1'b1;
        next_s();
        wave[0] = txd[0];
        @(negedge clk);
        req[0]  = 1'b0;
        for (int i = 1; i < 100; i++) begin
            next_s();
            wave[i] = txd[0];
        end
        bad = 0;
        for (int i = 0; i < 100; i++) if (wave[i] !== pat[i/10]) bad++;
        check("byte0_wave_bad_cycles", 32'(bad), 32'd0);
        wait_for(0, 1, 2000, "timing_finish");
        repeat (20) next_s();
        check("timing_msg_diff", 32'(msg_diff("LEDR=1111111111\r\n")), 32'd0);

        // Snapshot and coalescing.
        rx_log.delete();
        @(negedge clk);
        done_cnt[0] = 0;
        ledr[0] = 10'h000;
        req[0]  = 1'b1;
        @(negedge clk);
        req[0]  = 1'b0;
        repeat (300) next_s();
        @(negedge clk);
        ledr[0] = 10'h201;
        repeat (300) next_s();
        pulse_req(0);
        repeat (200) next_s();
        @(negedge clk);
        ledr[0] = 10'h200;
        repeat (200) next_s();
        pulse_req(0);
        wait_for(0, 2, 2000, "coalesce_first_done");
        gap = 0;
        do begin
            next_s();
            gap++;
        end while (!busy[0] && gap < 10);
        check("coalesce_restart_gap", 32'(gap), 32'd1);
        wait_for(0, 1, 2000, "coalesce_finish");
        repeat (50) next_s();
        check("coalesce_msg_diff",
              32'(msg_diff("LEDR=0000000000\r\nLEDR=1000000000\r\n")), 32'd0);
        check("coalesce_done_count", 32'(done_cnt[0]), 32'd2);
        check("coalesce_no_third", 32'(busy[0]), 32'd0);

        // Auto report on instance 0, nothing on instance 1.
        rx_log.delete();
        @(negedge clk);
        busy_cnt[1] = 0; lo_cnt[1] = 0;
        ledr[0] = 10'h002;
        ledr[1] = 10'h002;
        wait_for(0, 0, 50, "auto_start");
        wait_for(0, 1, 2000, "auto_finish");
        repeat (20) next_s();
        check("auto_msg_diff", 32'(msg_diff("LEDR=0000000010\r\n")), 32'd0);
        check("manual_no_busy", 32'(busy_cnt[1]), 32'd0);
        check("manual_no_low", 32'(lo_cnt[1]), 32'd0);

        // Zero-latency request, then reset during byte 7 with pending set.
        @(negedge clk);
        req[1] = 1'b1;
        next_s();
        check("req_latency_txd", 32'(txd[1]), 32'd0);
        check("req_latency_busy", 32'(busy[1]), 32'd1);
        @(negedge clk);
        req[1] = 1'b0;
        repeat (740) next_s();
        pulse_req(1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_txd", 32'(txd[1]), 32'd1);
        check("async_reset_busy", 32'(busy[1]), 32'd0);
        repeat (3) next_s();
        rx_log.delete();
        @(negedge clk);
        rst = 1'b0;
        busy_cnt[1] = 0; lo_cnt[1] = 0;
        // instance 0 still sees LEDs=0x002 against a cleared previous value
        wait_for(0, 0, 50, "post_reset_auto_start");
        wait_for(0, 1, 2000, "post_reset_auto_finish");
        repeat (20) next_s();
        check("post_reset_auto_msg", 32'(msg_diff("LEDR=0000000010\r\n")), 32'd0);
        check("post_reset_manual_busy", 32'(busy_cnt[1]), 32'd0);
        check("post_reset_manual_low", 32'(lo_cnt[1]), 32'd0);

        // Trigger in the cycle done is high, then trigger sampled at the done edge.
        @(negedge clk);
        done_cnt[1] = 0;
        req[1] = 1'b1;
        next_s();
        check("done_test_start", 32'(busy[1]), 32'd1);
        @(negedge clk);
        req[1] = 1'b0;
        wait_for(1, 2, 2000, "done_test_first_done");
        @(negedge clk);
        req[1] = 1'b1;
        next_s();
        check("done_cycle_req_busy", 32'(busy[1]), 32'd1);
        check("done_cycle_req_txd", 32'(txd[1]), 32'd0);
        @(negedge clk);
        req[1] = 1'b0;
        repeat (MSG_CYC - 1) next_s();
        @(negedge clk);
        req[1] = 1'b1;
        next_s();
        check("done_edge_done", 32'(done[1]), 32'd1);
        check("done_edge_busy_low", 32'(busy[1]), 32'd0);
        @(negedge clk);
        req[1] = 1'b0;
        next_s();
        check("done_edge_restart", 32'(busy[1]), 32'd1);
        wait_for(1, 1, 2000, "done_test_finish");
        check("done_test_count", 32'(done_cnt[1]), 32'd3);

        // Randomized traffic on both instances.
        for (int c = 0; c < 16000; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if ($urandom_range(0, 599) == 0) ledr[d] = 10'($urandom_range(0, 1023));
                req[d] = ($urandom_range(0, 699) == 0);
            end
        end
        @(negedge clk);
        req[0] = 1'b0;
        req[1] = 1'b0;
        repeat (3600) next_s();
        check("final_idle0", 32'(busy[0]), 32'd0);
        check("final_idle1", 32'(busy[1]), 32'd0);
        check("final_exp_q_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/led_status_tx.md
# led_status_tx

Reports the current red-LED state back to the host over the UART link, the reverse path of the command receiver that drives `LEDR[9:0]`. On a request pulse, or automatically when the LED vector changes, it snapshots the 10-bit LED state. It then serialises a fixed 17-byte ASCII message as 8N1 frames on `uart_txd`. It sits beside the LED controller and shares its clock and the board UART pins.

## Interface

Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: serial bit rate.
- `CLKS_PER_BIT`, default `CLK_FREQ/BAUD` (integer division; 434 at defaults): cycles per serial bit. Must be ≥ 2.
- `AUTO_REPORT`, default 1: when 1, any change of `ledr_state` requests a report.

Ports:
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `ledr_state`, input, 10: current LED vector, from `ledr_out` of the LED controller.
- `report_req`, input, 1: single-cycle request to send a report.
- `uart_txd`, output, 1: serial output. Idles high.
- `busy`, output, 1: high while a message is in flight.
- `done`, output, 1: one-cycle pulse when the last stop bit of a message completes.

## Operation

- Message: "LEDR=" (0x4C 0x45 0x44 0x52 0x3D), then 10 characters for `ledr_state[9]` down to `[0]` ('1'=0x31, '0'=0x30), then CR (0x0D) and LF (0x0A). That is 17 bytes, index 0..16.
- The message uses a snapshot of `ledr_state` taken in the cycle the message starts. Later changes do not alter a message in flight.
- Frame format: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly `CLKS_PER_BIT` cycles. Frames within one message are back-to-back, with no idle gap.
- State machine:
  - IDLE → START: when a trigger (`report_req`, or pending) is present.
  - START → DATA: after the start bit's `CLKS_PER_BIT` cycles.
  - DATA → STOP: after bit 7.
  - STOP → START: when byte index < 16; the index increments.
  - STOP → IDLE: when byte index = 16; `done` pulses.
- Bit counter counts 0..7. Baud counter counts 0..`CLKS_PER_BIT`-1 and reloads at each bit boundary. Byte index counts 0..16 and resets to 0 at message start.
- Pending flag:
  - Set by `report_req` while busy.
  - Set, when `AUTO_REPORT`=1, by `ledr_state` ≠ the previous-cycle registered value (in any state).
  - Cleared when a message starts.
  - Multiple triggers during one message coalesce into one follow-up message.
- Simultaneous `report_req` and change detect in IDLE: one message.
- Trigger on the same cycle as `done`: sets pending; it is not lost.
- The previous-value register resets to 0. With `AUTO_REPORT`=1, a nonzero `ledr_state` after reset produces one report.

## Timing

- Reset values: `uart_txd`=1, `busy`=0, `done`=0, pending=0, state IDLE, all counters 0.
- Reset asserted mid-message:
  - `uart_txd` goes to 1 immediately (asynchronously).
  - The message is abandoned and nothing resumes after reset.
- Trigger sampled at edge N in IDLE: at edge N, `busy`=1 and `uart_txd`=0 (start bit). The start bit therefore occupies cycles N..N+`CLKS_PER_BIT`-1.
- Message length: 170×`CLKS_PER_BIT` cycles from the start-bit edge to the `done` edge.
- At the `done` edge, `busy` falls to 0 and `uart_txd` stays 1.
- With pending set, the next message starts at the following edge. `busy` is low for exactly one cycle between messages.
- `report_req` in IDLE with `AUTO_REPORT`=0 and no change: latency is 0 cycles to the start bit.

## Test plan

- Basic report:
  - Stimulus: `CLK_FREQ`=1000, `BAUD`=100 (`CLKS_PER_BIT`=10), `ledr_state`=10'b0000000001, pulse `report_req`.
  - Required: the decoded bytes are "LEDR=0000000001\r\n", `busy` is high for 1700 cycles, and `done` pulses once.
- Bit timing:
  - Stimulus: `ledr_state`=10'h3FF.
  - Required: each bit is exactly 10 cycles, byte 0 is sent as the LSB-first pattern 0,0,0,1,1,0,0,1,0 followed by stop 1, and the ASCII payload is '1' ×10.
- Snapshot and coalescing:
  - Stimulus: start a report with 10'h000, then toggle `ledr_state` to 10'h201 and back to 10'h200 mid-message, and pulse `report_req` twice.
  - Required: the first message reads all '0'; exactly one follow-up message reads "LEDR=1000000000\r\n", and it starts one cycle after the first `done`.
- Auto report:
  - Stimulus: `AUTO_REPORT`=1, idle, `ledr_state` changes from 0 to 10'h002 with no `report_req`.
  - Required: one message reads "...0000000010\r\n".
  - With `AUTO_REPORT`=0, the same stimulus leaves `uart_txd` high.
- Reset mid-message:
  - Stimulus: assert `rst` during byte 7's data bits, with pending set.
  - Required: `uart_txd`=1 and `busy`=0 in the same cycle; after release with stable inputs (`AUTO_REPORT`=0), no message is sent.
- Trigger on the `done` cycle:
  - Stimulus: pulse `report_req` on the exact cycle `done` is high.
  - Required: a second message starts on the next edge.
